// File: rtl/hog_stream_pkg.sv
// hog_stream_pkg: shared types, default sizes and pick helper
// for the window stream path (serializer, arbiter, ext bus).
package hog_stream_pkg;

  typedef enum logic {
    IDLE,
    LOCK
  } state_t;

  localparam int DEF_BUS_WIDTH = 128;
  localparam int DEF_LEVELS    = 7;
  localparam int DEF_BEATS     = 10;
  localparam int MAX_LEVELS    = 32;

  // First set bit of req[n-1:0] searching upward from ptr,
  // wrapping modulo n. Returns 0 when nothing is set.
  function automatic int first_set_from(
    input logic [MAX_LEVELS-1:0] req,
    input int                    ptr,
    input int                    n
  );
    int   idx;
    logic hit;
    first_set_from = 0;
    hit = 1'b0;
    for (int i = 0; i < MAX_LEVELS; i++) begin
      if (i < n) begin
        idx = ptr + i;
        if (idx >= n) idx = idx - n;
        if (!hit && req[idx]) begin
          hit = 1'b1;
          first_set_from = idx;
        end
      end
    end
  endfunction

endpackage

// File: rtl/hog_stream_arbiter_rr_picker.sv
// rr_picker: combinational grant pick, rotating from ptr (mode=0)
// or lowest index first (mode=1). Ports: req, ptr, mode -> grant, any.
module rr_picker
  import hog_stream_pkg::*;
#(
  parameter  int LEVELS  = DEF_LEVELS,
  localparam int LEVEL_W = $clog2(LEVELS)
) (
  input  logic [LEVELS-1:0]  req,
  input  logic [LEVEL_W-1:0] ptr,
  input  logic               mode,
  output logic [LEVEL_W-1:0] grant,
  output logic               any
);

  logic [MAX_LEVELS-1:0] req_ext;
  int                    start;

  always_comb begin
    req_ext = MAX_LEVELS'(req);
    start   = mode ? 0 : int'(ptr);
    grant   = LEVEL_W'(first_set_from(req_ext, start, LEVELS));
    any     = |req;
  end

endmodule

// File: rtl/hog_stream_arbiter.sv
// hog_stream_arbiter: merges LEVELS beat streams onto one bus,
// holding the grant for a whole BEATS-beat window.
// Ports: clk, rst; in_valid/in_ready/in_stream per level;
// out_valid/out_ready/out_stream/out_level/out_last;
// mode, level_enable; cnt_sel/cnt_clear/cnt_out window counters.
module hog_stream_arbiter
  import hog_stream_pkg::*;
#(
  parameter  int BUS_WIDTH = DEF_BUS_WIDTH,
  parameter  int LEVELS    = DEF_LEVELS,
  parameter  int BEATS     = DEF_BEATS,
  parameter  int CNT_WIDTH = 32,
  localparam int LEVEL_W   = $clog2(LEVELS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [LEVELS-1:0]           in_valid,
  output logic [LEVELS-1:0]           in_ready,
  input  logic [BUS_WIDTH*LEVELS-1:0] in_stream,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [BUS_WIDTH-1:0]        out_stream,
  output logic [LEVEL_W-1:0]          out_level,
  output logic                        out_last,
  input  logic                        mode,
  input  logic [LEVELS-1:0]           level_enable,
  input  logic [LEVEL_W-1:0]          cnt_sel,
  input  logic                        cnt_clear,
  output logic [CNT_WIDTH-1:0]        cnt_out
);

  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [LEVEL_W-1:0] LAST_LVL  = LEVEL_W'(LEVELS - 1);

  state_t               state;
  logic [LEVEL_W-1:0]   grant;
  logic [LEVEL_W-1:0]   rr_ptr;
  logic [LEVEL_W-1:0]   pick;
  logic                 pick_any;
  logic [BEAT_W-1:0]    beat_cnt;
  logic [CNT_WIDTH-1:0] cnt [LEVELS];
  logic [BUS_WIDTH-1:0] g_beat;
  logic                 g_valid;
  logic                 slot_free;
  logic                 xfer;
  logic                 win_done;

  rr_picker #(
    .LEVELS (LEVELS)
  ) u_pick (
    .req   (in_valid & level_enable),
    .ptr   (rr_ptr),
    .mode  (mode),
    .grant (pick),
    .any   (pick_any)
  );

  // Granted-slice mux; only the locked level sees ready.
  always_comb begin
    g_beat    = '0;
    g_valid   = 1'b0;
    in_ready  = '0;
    slot_free = !out_valid || out_ready;
    for (int j = 0; j < LEVELS; j++) begin
      if (grant == LEVEL_W'(j)) begin
        g_beat      = in_stream[j*BUS_WIDTH +: BUS_WIDTH];
        g_valid     = in_valid[j];
        in_ready[j] = (state == LOCK) && slot_free;
      end
    end
    xfer     = (state == LOCK) && g_valid && slot_free;
    win_done = xfer && (beat_cnt == LAST_BEAT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      rr_ptr     <= '0;
      beat_cnt   <= '0;
      out_valid  <= 1'b0;
      out_stream <= '0;
      out_level  <= '0;
      out_last   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            grant <= pick;
            state <= LOCK;
          end
        end
        LOCK: begin
          if (xfer) begin
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              state    <= IDLE;
              rr_ptr   <= (grant == LAST_LVL) ?
                          '0 : grant + 1'b1;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
      endcase
      if (xfer) begin
        out_valid  <= 1'b1;
        out_stream <= g_beat;
        out_level  <= grant;
        out_last   <= (beat_cnt == LAST_BEAT);
      end else if (out_ready) begin
        out_valid  <= 1'b0;
      end
    end
  end

  // Saturating per-level window counters; clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < LEVELS; j++) cnt[j] <= '0;
    end else begin
      for (int j = 0; j < LEVELS; j++) begin
        if (cnt_clear) begin
          cnt[j] <= '0;
        end else if (win_done && grant == LEVEL_W'(j) &&
                     cnt[j] != '1) begin
          cnt[j] <= cnt[j] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    cnt_out = '0;
    for (int j = 0; j < LEVELS; j++) begin
      if (cnt_sel == LEVEL_W'(j)) cnt_out = cnt[j];
    end
  end

endmodule

// File: tb/tb_hog_stream_arbiter.sv
// tb_hog_stream_arbiter: directed + random stimulus against a
// window-level reference model of the arbiter.
module tb_hog_stream_arbiter;

  localparam int BW = 128;
  localparam int L  = 7;
  localparam int B  = 10;
  localparam int CW = 32;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [L-1:0]  in_valid = '0;
  logic [L-1:0]  in_ready;
  logic [BW*L-1:0] in_stream = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [BW-1:0] out_stream;
  logic [LW-1:0] out_level;
  logic          out_last;
  logic          mode = 1'b0;
  logic [L-1:0]  level_enable = '0;
  logic [LW-1:0] cnt_sel = '0;
  logic          cnt_clear = 1'b0;
  logic [CW-1:0] cnt_out;

  hog_stream_arbiter #(
    .BUS_WIDTH (BW),
    .LEVELS    (L),
    .BEATS     (B),
    .CNT_WIDTH (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_stream    (in_stream),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_stream   (out_stream),
    .out_level    (out_level),
    .out_last     (out_last),
    .mode         (mode),
    .level_enable (level_enable),
    .cnt_sel      (cnt_sel),
    .cnt_clear    (cnt_clear),
    .cnt_out      (cnt_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Reference model: one window owner at a time, one output slot.
  bit          m_locked = 0;
  bit          m_ov = 0;
  bit          m_last = 0;
  bit          room;
  int          m_grant = 0;
  int          m_beat = 0;
  int          m_ptr = 0;
  int          m_lvl = 0;
  logic [BW-1:0] m_data = '0;
  int unsigned m_cnt [L];

  function automatic int m_pick(input logic [L-1:0] r,
                                input int p, input bit fp);
    for (int k = 0; k < L; k++) begin
      int idx;
      idx = fp ? k : (p + k) % L;
      if (r[idx]) return idx;
    end
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_locked = 0; m_ov = 0; m_last = 0;
      m_grant = 0; m_beat = 0; m_ptr = 0; m_lvl = 0;
      m_data = '0;
      for (int j = 0; j < L; j++) m_cnt[j] = 0;
    end else begin
      room = !m_ov || out_ready;
      if (!m_locked) begin
        if ((in_valid & level_enable) != '0) begin
          m_grant  = m_pick(in_valid & level_enable, m_ptr, mode);
          m_locked = 1;
        end
        if (out_ready) m_ov = 0;
      end else if (in_valid[m_grant] && room) begin
        m_ov   = 1;
        m_data = in_stream[m_grant*BW +: BW];
        m_lvl  = m_grant;
        m_last = (m_beat == B - 1);
        if (m_last) begin
          m_locked = 0;
          m_beat   = 0;
          m_ptr    = (m_grant + 1) % L;
          m_cnt[m_grant]++;
        end else begin
          m_beat++;
        end
      end else if (out_ready) begin
        m_ov = 0;
      end
      if (cnt_clear)
        for (int j = 0; j < L; j++) m_cnt[j] = 0;
    end
  end

  int checks = 0;
  int errors = 0;
  int obs_lvl[$];
  bit obs_last[$];
  int acc [L];
  int first_ov = -1;

  task automatic chk(input string nm, input logic [BW-1:0] act,
                     input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int n_lasts();
    int n = 0;
    foreach (obs_last[i]) if (obs_last[i]) n++;
    return n;
  endfunction

  // Per-cycle compare against the model plus beat log.
  task automatic sample();
    logic [L-1:0] er;
    int unsigned  ec;
    if (rst) begin
      obs_lvl.delete();
      obs_last.delete();
      for (int j = 0; j < L; j++) acc[j] = 0;
      first_ov = -1;
    end else begin
      chk("out_valid", out_valid, m_ov);
      if (m_ov) begin
        chk("out_stream", out_stream, m_data);
        chk("out_level", out_level, m_lvl);
        chk("out_last", out_last, m_last);
      end
      er = '0;
      if (m_locked && (!m_ov || out_ready)) er[m_grant] = 1'b1;
      chk("in_ready", in_ready, er);
      ec = (cnt_sel < L) ? m_cnt[cnt_sel] : 0;
      chk("cnt_out", cnt_out, ec);
      if (out_valid && first_ov < 0) first_ov = cyc;
      if (out_valid && out_ready) begin
        obs_lvl.push_back(int'(out_level));
        obs_last.push_back(out_last);
      end
      for (int j = 0; j < L; j++)
        if (in_valid[j] && in_ready[j]) acc[j]++;
    end
  endtask

  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    for (int k = 0; k < L * 4; k++) in_stream[k*32 +: 32] = $urandom;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_stream", out_stream, 0);
    chk("rst_out_level", out_level, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_cnt_out", cnt_out, 0);
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_lasts(input int n, input int budget);
    for (int k = 0; k < budget && n_lasts() < n; k++) step();
    chk("wait_timeout", n_lasts() >= n, 1);
  endtask

  int bad;
  int t0;
  int drop;
  int exp_rr [6] = '{0, 2, 5, 0, 2, 5};

  initial begin
    step();
    do_reset();

    // Single level 3
    level_enable = '1; mode = 0; out_ready = 1; cnt_sel = 3;
    in_valid = 7'b0001000;
    t0 = cyc;
    wait_lasts(1, 40);
    chk("p1_latency", first_ov, t0 + 2);
    chk("p1_nbeats", obs_lvl.size(), 10);
    bad = 0;
    foreach (obs_lvl[i])
      if (obs_lvl[i] != 3 || obs_last[i] != (i == 9)) bad++;
    chk("p1_beats", bad, 0);
    chk("p1_cnt3", cnt_out, 1);
    in_valid = '0;

    // Round robin over 0, 2, 5
    do_reset();
    in_valid = 7'b0100101;
    wait_lasts(6, 200);
    bad = 0;
    for (int i = 0; i < 60 && i < obs_lvl.size(); i++)
      if (obs_lvl[i] != exp_rr[i/10] ||
          obs_last[i] != (i % 10 == 9)) bad++;
    chk("p2_order", bad, 0);
    cnt_sel = 0; #1 chk("p2_cnt0", cnt_out, 2);
    cnt_sel = 2; #1 chk("p2_cnt2", cnt_out, 2);
    cnt_sel = 5; #1 chk("p2_cnt5", cnt_out, 2);

    // Fixed priority, levels 1 and 4
    do_reset();
    mode = 1; in_valid = 7'b0010010;
    wait_lasts(5, 200);
    bad = 0;
    foreach (obs_lvl[i]) if (obs_lvl[i] != 1) bad++;
    chk("p3_only1", bad, 0);
    cnt_sel = 4; #1 chk("p3_cnt4", cnt_out, 0);
    cnt_sel = 1; #1 chk("p3_cnt1", cnt_out, 5);

    // Backpressure and mid-window stall of level 0
    do_reset();
    mode = 0; in_valid = 7'b1000001; drop = 0;
    for (int k = 0; k < 400 && n_lasts() < 2; k++) begin
      out_ready = 1'($urandom % 2);
      if (acc[0] >= 4 && drop < 3) begin
        in_valid[0] = 1'b0;
        drop++;
      end else begin
        in_valid[0] = 1'b1;
      end
      step();
    end
    out_ready = 1;
    chk("p4_done", n_lasts() >= 2, 1);
    bad = 0;
    for (int i = 0; i < 20 && i < obs_lvl.size(); i++)
      if (obs_lvl[i] != (i < 10 ? 0 : 6) ||
          obs_last[i] != (i % 10 == 9)) bad++;
    chk("p4_order", bad, 0);

    // Disabled level 2 never granted
    do_reset();
    level_enable = 7'b1111011; in_valid = 7'b0001100;
    wait_lasts(3, 200);
    bad = 0;
    foreach (obs_lvl[i]) if (obs_lvl[i] == 2) bad++;
    chk("p5_no2", bad, 0);

    // Enable dropped mid-window, clear on final beat
    do_reset();
    level_enable = '1; in_valid = 7'b0000100; cnt_sel = 2;
    for (int k = 0; k < 10 && !in_ready[2]; k++) step();
    level_enable[2] = 1'b0;
    for (int k = 0; k < 40 && n_lasts() < 1; k++) begin
      cnt_clear = (acc[2] == 9);
      step();
    end
    cnt_clear = 0;
    chk("p6_nbeats", obs_lvl.size(), 10);
    #1 chk("p6_cnt2", cnt_out, 0);

    // Reset mid-window of level 1
    do_reset();
    level_enable = '1; in_valid = 7'b0000010;
    for (int k = 0; k < 40 && acc[1] < 5; k++) step();
    do_reset();
    wait_lasts(1, 40);
    chk("p7_nbeats", obs_lvl.size(), 10);
    bad = 0;
    foreach (obs_lvl[i])
      if (obs_lvl[i] != 1 || obs_last[i] != (i == 9)) bad++;
    chk("p7_beats", bad, 0);

    // Random traffic
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      in_valid     = L'($urandom);
      level_enable = L'($urandom | $urandom);
      if ($urandom % 64 == 0) mode = ~mode;
      out_ready    = ($urandom % 4) != 0;
      cnt_sel      = LW'($urandom);
      cnt_clear    = ($urandom % 50) == 0;
      if ($urandom % 700 == 0) do_reset();
      else step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
